// File: rtl/mem_arbiter.sv
// mem_arbiter: funnels the instruction-side (a) and data-side (b) L1 cache
// line requests onto the single physical memory bus.
// - Round-robin fairness applies when both ports contend.
// - Request fields are latched on the grant edge, so requester input changes
//   during a transaction do not reach the bus.
// - Completion is returned as a registered one-cycle pulse on the granted port.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_read,
    input  logic [ADDR_WIDTH-1:0] a_address,
    output logic [LINE_WIDTH-1:0] a_rdata,
    output logic                  a_resp,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [LINE_WIDTH-1:0] b_wdata,
    output logic [LINE_WIDTH-1:0] b_rdata,
    output logic                  b_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;
    logic   prio_b;   // 1: port b wins the next contended grant
    logic   b_req;

    // Port b wins when it alone requests, or when both request and it holds priority.
    function automatic logic grant_b(input logic req_a, input logic req_b,
                                     input logic favor_b);
        return req_b && (!req_a || favor_b);
    endfunction

    // A writeback and a read from port b are one request; write takes precedence.
    assign b_req = b_read | b_write;

    // Arbitration FSM: grant in IDLE, hold the latched strobe until memory
    // completes, then pulse the granted port's response for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            prio_b       <= 1'b1;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            a_resp       <= 1'b0;
            b_resp       <= 1'b0;
        end else begin
            a_resp <= 1'b0;
            b_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_b(a_read, b_req, prio_b)) begin
                        state        <= SERVE_B;
                        prio_b       <= 1'b0;
                        pmem_address <= b_address;
                        if (b_write) begin
                            pmem_write <= 1'b1;
                            pmem_wdata <= b_wdata;
                        end else begin
                            pmem_read <= 1'b1;
                        end
                    end else if (a_read) begin
                        state        <= SERVE_A;
                        prio_b       <= 1'b1;
                        pmem_address <= a_address;
                        pmem_read    <= 1'b1;
                    end
                end
                SERVE_A: begin
                    if (pmem_resp) begin
                        a_rdata   <= pmem_rdata;
                        pmem_read <= 1'b0;
                        a_resp    <= 1'b1;
                        state     <= RESP;
                    end
                end
                SERVE_B: begin
                    if (pmem_resp) begin
                        // Writebacks return nothing; the last read line is kept.
                        if (!pmem_write) begin
                            b_rdata <= pmem_rdata;
                        end
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        b_resp     <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
